wb_uart_tx: RTL and testbench

WB_UART_TX -- requirements
Module: wb_uart_tx

---
 rtl/wb_uart_tx_pkg.sv | 34 +++
 rtl/wb_uart_tx_sync_fifo.sv | 53 +++++
 rtl/wb_uart_tx.sv | 205 ++++++++++++++++++++
 tb/tb_wb_uart_tx.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_uart_tx_pkg.sv
// Shared IO definitions for the Wishbone UART transmitter: register word
// offsets, STATUS bit positions, transmitter state encodings and a helper
// that saturates the FIFO occupancy into the 4-bit STATUS count field.
package wb_uart_tx_pkg;

  // Register word offsets on the IO Wishbone port
  localparam logic [5:0] ADDR_TXDATA  = 6'd0;
  localparam logic [5:0] ADDR_STATUS  = 6'd1;
  localparam logic [5:0] ADDR_DIVISOR = 6'd2;
  localparam logic [5:0] ADDR_CTRL    = 6'd3;

  // STATUS bit positions; bits 7:4 hold the saturated FIFO count
  localparam int unsigned STAT_EMPTY = 0;
  localparam int unsigned STAT_FULL  = 1;
  localparam int unsigned STAT_BUSY  = 2;
  localparam int unsigned STAT_OVF   = 3;

  // CTRL bit positions
  localparam int unsigned CTRL_TXEN  = 0;
  localparam int unsigned CTRL_IRQEN = 1;

  // Transmitter state encodings
  typedef logic [1:0] tx_state_t;
  localparam tx_state_t S_IDLE  = 2'd0;
  localparam tx_state_t S_START = 2'd1;
  localparam tx_state_t S_DATA  = 2'd2;
  localparam tx_state_t S_STOP  = 2'd3;

  function automatic logic [3:0] sat_count(input logic [15:0] count);
    if (count > 16'd15) return 4'hF;
    return count[3:0];
  endfunction

endpackage

// File: rtl/wb_uart_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead read data.
// Ports: clk, rst (sync, active-high), push/din, pop/dout, full, empty,
// count (occupancy, 0..DEPTH). Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone-attached 8N1 UART transmitter with TX FIFO.
// Ports: clk, rst (sync, active-high); io__* Wishbone slave (6-bit word
// address, 32-bit data, byte selects, single-cycle registered ack/err);
// uart_tx serial line (idle high); irq level interrupt (TX drained).
// Registers: 0 TXDATA (W), 1 STATUS (R/W1C), 2 DIVISOR (R/W), 3 CTRL (R/W).
module wb_uart_tx #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  io__addr,
  input  logic [31:0] io__dat_w,
  input  logic [3:0]  io__sel,
  input  logic        io__we,
  input  logic        io__cyc,
  input  logic        io__stb,
  output logic [31:0] io__dat_r,
  output logic        io__ack,
  output logic        io__err,
  output logic        uart_tx,
  output logic        irq
);

  import wb_uart_tx_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic            req;
  logic            addr_ok;
  logic            wr_req;
  logic            fifo_push;
  logic            fifo_pop;
  logic [7:0]      fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [15:0]     divisor;
  logic [1:0]      ctrl;
  logic            overflow;
  logic [7:0]      status;
  logic [31:0]     rd_val;
  tx_state_t       state;
  logic [15:0]     cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            bit_end;
  logic            tx_busy;
  logic            unused_bits;

  assign unused_bits = ^{io__dat_w[31:16], io__sel[3:2]};

  // A request is taken only while no response is on the bus, so a
  // strobe held across the ack cycle is not double-counted.
  assign req     = io__cyc && io__stb && !io__ack && !io__err;
  assign addr_ok = (io__addr[5:2] == 4'd0);
  assign wr_req  = req && io__we;

  // Bytes arriving while full are dropped and flagged, never queued.
  assign fifo_push = wr_req && (io__addr == ADDR_TXDATA) && io__sel[0] && !fifo_full;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (io__dat_w[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx_busy = (state != S_IDLE);

  always_comb begin
    status             = '0;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_FULL]  = fifo_full;
    status[STAT_BUSY]  = tx_busy;
    status[STAT_OVF]   = overflow;
    status[7:4]        = sat_count(16'(fifo_count));
  end

  always_comb begin
    rd_val = '0;
    case (io__addr)
      ADDR_STATUS:  rd_val[7:0]  = status;
      ADDR_DIVISOR: rd_val[15:0] = divisor;
      ADDR_CTRL:    rd_val[1:0]  = ctrl;
      default:      rd_val       = '0;
    endcase
  end

  // Bus response: one cycle after the request, exactly one of ack/err.
  always_ff @(posedge clk) begin
    if (rst) begin
      io__ack   <= 1'b0;
      io__err   <= 1'b0;
      io__dat_r <= '0;
    end else begin
      io__ack   <= req && addr_ok;
      io__err   <= req && !addr_ok;
      io__dat_r <= (req && !io__we && addr_ok) ? rd_val : '0;
    end
  end

  // Register writes honour byte selects.
  always_ff @(posedge clk) begin
    if (rst) begin
      divisor  <= DIV_RESET;
      ctrl     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_req && (io__addr == ADDR_DIVISOR)) begin
        if (io__sel[0]) divisor[7:0]  <= io__dat_w[7:0];
        if (io__sel[1]) divisor[15:8] <= io__dat_w[15:8];
      end
      if (wr_req && (io__addr == ADDR_CTRL) && io__sel[0])
        ctrl <= io__dat_w[1:0];
      if (wr_req && (io__addr == ADDR_TXDATA) && io__sel[0] && fifo_full)
        overflow <= 1'b1;
      else if (wr_req && (io__addr == ADDR_STATUS) && io__sel[0] && io__dat_w[STAT_OVF])
        overflow <= 1'b0;
    end
  end

  // cnt counts down from the divisor latched at each bit boundary, so a
  // DIVISOR write only affects the next bit.
  assign bit_end  = (cnt == '0);
  assign fifo_pop = ctrl[CTRL_TXEN] && !fifo_empty &&
                    ((state == S_IDLE) || ((state == S_STOP) && bit_end));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      uart_tx <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (fifo_pop) begin
            state   <= S_START;
            cnt     <= divisor;
            shreg   <= fifo_dout;
            uart_tx <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            cnt     <= divisor;
            bit_idx <= '0;
            uart_tx <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt <= divisor;
            if (bit_idx == 3'd7) begin
              state   <= S_STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            // Back-to-back frames: the next start bit follows the stop bit directly.
            if (fifo_pop) begin
              state   <= S_START;
              cnt     <= divisor;
              shreg   <= fifo_dout;
              uart_tx <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= ctrl[CTRL_IRQEN] && fifo_empty && !tx_busy;
  end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Self-checking bench for wb_uart_tx: register-map vector table, serial
// scoreboard fed by TXDATA writes, and directed multi-cycle sequences.
module tb_wb_uart_tx;

  import wb_uart_tx_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  addr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;
  logic        tx;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  logic [7:0]  exp_q[$];
  int          start_q[$];
  logic        mon_en = 1'b0;
  logic        mon_busy = 1'b0;
  logic [15:0] cur_div = 16'd433;

  typedef struct {
    string       name;
    logic [5:0]  addr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_ack;
    logic        exp_err;
    logic        chk_dat;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[$];

  wb_uart_tx #(
    .FIFO_DEPTH (8),
    .DIV_RESET  (16'd433)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .io__addr  (addr),
    .io__dat_w (dat_w),
    .io__sel   (sel),
    .io__we    (we),
    .io__cyc   (cyc),
    .io__stb   (stb),
    .io__dat_r (dat_r),
    .io__ack   (ack),
    .io__err   (err),
    .uart_tx   (tx),
    .irq       (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [5:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, output logic k, output logic e,
                      output logic [31:0] dr);
    @(negedge clk);
    addr = a; we = w; dat_w = d; sel = s; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    k = ack; e = err; dr = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("resp_one_cycle", 32'({ack, err}), 32'd0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    logic k, e;
    logic [31:0] dr;
    xfer(a, 1'b1, d, s, k, e, dr);
    chk("wr_ack", 32'(k), 32'd1);
  endtask

  task automatic rd(input string name, input logic [5:0] a, input logic [31:0] exp);
    logic k, e;
    logic [31:0] dr;
    xfer(a, 1'b0, '0, 4'hF, k, e, dr);
    chk({name, "_ack"}, 32'(k), 32'd1);
    chk(name, dr, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic expect_tx);
    if (expect_tx) exp_q.push_back(b);
    wr(ADDR_TXDATA, {24'h0, b}, 4'h1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", (exp_q.size() == 0 && !mon_busy) ? 32'd1 : 32'd0, 32'd1);
    repeat (int'(cur_div) + 4) @(negedge clk);
  endtask

  task automatic add_vec(input string n, input logic [5:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] s, input logic ea,
                         input logic ee, input logic cd, input logic [31:0] ed);
    vec_t v;
    v.name = n; v.addr = a; v.we = w; v.dat = d; v.sel = s;
    v.exp_ack = ea; v.exp_err = ee; v.chk_dat = cd; v.exp_dat = ed;
    vecs.push_back(v);
  endtask

  // Serial monitor: samples each bit mid-cell and checks against the scoreboard.
  initial begin
    logic [15:0] d;
    logic [7:0]  data;
    logic        stop;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        mon_busy = 1'b1;
        d = cur_div;
        start_q.push_back(cyc_cnt);
        repeat ((int'(d) + 1) / 2) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
          repeat (int'(d) + 1) @(negedge clk);
          data[j] = tx;
        end
        repeat (int'(d) + 1) @(negedge clk);
        stop = tx;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got byte 0x%02h expected no frame", data);
        end else begin
          chk("sb_byte", 32'(data), 32'(exp_q.pop_front()));
        end
        chk("sb_stop", 32'(stop), 32'd1);
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    logic        k, e;
    logic [31:0] dr;
    logic [39:0] obs, expv;
    logic [7:0]  a5;
    int          n, n1, n2, n3;

    addr = '0; dat_w = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_dat_r", dat_r, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Register map table
    add_vec("div_reset",  ADDR_DIVISOR, 1'b0, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h1B1);
    add_vec("stat_reset", ADDR_STATUS,  1'b0, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h01);
    add_vec("ctrl_reset", ADDR_CTRL,    1'b0, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h0);
    add_vec("txdata_rd",  ADDR_TXDATA,  1'b0, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h0);
    add_vec("rd_addr5",   6'd5,         1'b0, 32'h0,        4'hF, 1'b0, 1'b1, 1'b0, 32'h0);
    add_vec("wr_addr63",  6'd63,        1'b1, 32'hFFFF,     4'hF, 1'b0, 1'b1, 1'b0, 32'h0);
    add_vec("div_sel1",   ADDR_DIVISOR, 1'b1, 32'h1234,     4'h1, 1'b1, 1'b0, 1'b0, 32'h0);
    add_vec("div_sel1_rd",ADDR_DIVISOR, 1'b0, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h0134);
    add_vec("div_sel0",   ADDR_DIVISOR, 1'b1, 32'hFFFF,     4'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    add_vec("div_sel0_rd",ADDR_DIVISOR, 1'b0, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h0134);
    add_vec("div_wr3",    ADDR_DIVISOR, 1'b1, 32'hABCD0003, 4'h3, 1'b1, 1'b0, 1'b0, 32'h0);
    add_vec("div_rd3",    ADDR_DIVISOR, 1'b0, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h3);
    add_vec("ctrl_wr2",   ADDR_CTRL,    1'b1, 32'hFFFFFFFE, 4'h1, 1'b1, 1'b0, 1'b0, 32'h0);
    add_vec("ctrl_rd2",   ADDR_CTRL,    1'b0, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h2);
    add_vec("ctrl_wr0",   ADDR_CTRL,    1'b1, 32'h0,        4'h1, 1'b1, 1'b0, 1'b0, 32'h0);
    add_vec("ctrl_rd0",   ADDR_CTRL,    1'b0, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h0);
    foreach (vecs[i]) begin
      xfer(vecs[i].addr, vecs[i].we, vecs[i].dat, vecs[i].sel, k, e, dr);
      chk({vecs[i].name, "_ack"}, 32'(k), 32'(vecs[i].exp_ack));
      chk({vecs[i].name, "_err"}, 32'(e), 32'(vecs[i].exp_err));
      if (vecs[i].chk_dat) chk(vecs[i].name, dr, vecs[i].exp_dat);
    end
    cur_div = 16'd3;
    mon_en = 1'b1;

    // Strobe held across the ack cycle: ack, gap, ack
    @(negedge clk);
    addr = ADDR_CTRL; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(negedge clk); chk("hold_ack1", 32'(ack), 32'd1);
    @(negedge clk); chk("hold_ack2", 32'(ack), 32'd0);
    @(negedge clk); chk("hold_ack3", 32'(ack), 32'd1);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk); chk("hold_ack4", 32'(ack), 32'd0);

    // 0xA5 frame timing at DIVISOR=3
    wr(ADDR_CTRL, 32'h1, 4'h1);
    a5 = 8'hA5;
    send_byte(a5, 1'b1);
    n = 0;
    while (tx !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    chk("a5_start_seen", (n < 20) ? 32'd1 : 32'd0, 32'd1);
    for (int k2 = 0; k2 < 40; k2++) begin
      obs[k2] = tx;
      if (k2 / 4 == 0)      expv[k2] = 1'b0;
      else if (k2 / 4 == 9) expv[k2] = 1'b1;
      else                  expv[k2] = a5[k2 / 4 - 1];
      @(negedge clk);
    end
    chk("a5_wave_lo", obs[31:0], expv[31:0]);
    chk("a5_wave_hi", 32'(obs[39:32]), 32'(expv[39:32]));
    wait_drain(200);
    rd("a5_status", ADDR_STATUS, 32'h01);

    // DIVISOR=0: one clock per bit, back-to-back frames
    wr(ADDR_DIVISOR, 32'h0, 4'h3);
    cur_div = 16'd0;
    start_q.delete();
    send_byte(8'h5A, 1'b1);
    send_byte(8'hC3, 1'b1);
    wait_drain(100);
    chk("div0_frames", start_q.size(), 32'd2);
    if (start_q.size() == 2) chk("div0_gap", start_q[1] - start_q[0], 32'd10);

    // Interrupt timing at DIVISOR=1
    wr(ADDR_DIVISOR, 32'h1, 4'h3);
    cur_div = 16'd1;
    wr(ADDR_CTRL, 32'h3, 4'h1);
    repeat (3) @(negedge clk);
    chk("irq_idle", 32'(irq), 32'd1);
    send_byte(8'h3C, 1'b1);
    chk("irq_fall", 32'(irq), 32'd0);
    chk("irq_frame_started", 32'(tx), 32'd0);
    n = 0;
    while (irq !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("irq_rise_lat", n, 10 * (int'(cur_div) + 1) + 1);
    wait_drain(100);

    // Overflow with transmitter disabled, then back-to-back drain
    wr(ADDR_CTRL, 32'h0, 4'h1);
    for (int b = 0; b < 9; b++) send_byte(8'h10 + 8'(b), (b < 8) ? 1'b1 : 1'b0);
    rd("ovf_status", ADDR_STATUS, 32'h8A);
    wr(ADDR_STATUS, 32'h8, 4'h1);
    rd("ovf_clr_status", ADDR_STATUS, 32'h82);
    start_q.delete();
    wr(ADDR_CTRL, 32'h1, 4'h1);
    wait_drain(400);
    chk("ovf_frames", start_q.size(), 32'd8);
    for (int i = 1; i < start_q.size(); i++)
      chk("ovf_b2b_gap", start_q[i] - start_q[i-1], 10 * (int'(cur_div) + 1));
    rd("ovf_final_status", ADDR_STATUS, 32'h01);

    // CTRL.bit0 cleared mid-frame: current frame completes, next byte held
    send_byte(8'h81, 1'b1);
    send_byte(8'h7E, 1'b0);
    wr(ADDR_CTRL, 32'h0, 4'h1);
    wait_drain(100);
    repeat (30) @(negedge clk);
    rd("hold_status", ADDR_STATUS, 32'h10);
    chk("hold_line", 32'(tx), 32'd1);
    exp_q.push_back(8'h7E);
    wr(ADDR_CTRL, 32'h1, 4'h1);
    wait_drain(100);
    rd("resume_status", ADDR_STATUS, 32'h01);

    // DIVISOR change mid start bit: start keeps old count, next bits use new
    mon_en = 1'b0;
    wr(ADDR_DIVISOR, 32'h7, 4'h3);
    cur_div = 16'd7;
    send_byte(8'h01, 1'b0);
    n1 = 0; n2 = 0; n3 = 0;
    fork
      begin
        while (tx === 1'b0 && n1 < 100) begin n1++; @(negedge clk); end
        while (tx === 1'b1 && n2 < 100) begin n2++; @(negedge clk); end
        while (tx === 1'b0 && n3 < 100) begin n3++; @(negedge clk); end
      end
      begin
        @(negedge clk);
        xfer(ADDR_DIVISOR, 1'b1, 32'h1, 4'h3, k, e, dr);
      end
    join
    chk("divchg_start_len", n1, 32'd8);
    chk("divchg_bit0_len", n2, 32'd2);
    chk("divchg_bits1_7_len", n3, 32'd14);
    cur_div = 16'd1;
    repeat (10) @(negedge clk);

    // Reset during DATA with a bus request pending
    wr(ADDR_DIVISOR, 32'h3, 4'h3);
    cur_div = 16'd3;
    send_byte(8'h00, 1'b0);
    repeat (8) @(negedge clk);
    chk("pre_rst_in_data", 32'(tx), 32'd0);
    rst = 1'b1;
    addr = ADDR_CTRL; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_irq", 32'(irq), 32'd0);
    chk("midrst_dat_r", dat_r, 32'd0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    cur_div = 16'd433;
    repeat (2) @(negedge clk);
    rd("postrst_status", ADDR_STATUS, 32'h01);
    rd("postrst_div", ADDR_DIVISOR, 32'h1B1);
    rd("postrst_ctrl", ADDR_CTRL, 32'h0);
    chk("postrst_line", 32'(tx), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
